// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LL  = 1'b1
  } port_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  // Round-robin step: after serving a port, the other one gets priority.
  function automatic port_e other_port(input port_e p);
    return (p == PORT_ALU) ? PORT_LL : PORT_ALU;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations: set on issue, cleared
// on port-1 writeback, and raises the decode stall on RAW/WAW hazards.
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic      issue_valid_i,
  input  reg_addr_t issue_rd_i,
  input  logic      clr_valid_i,
  input  reg_addr_t clr_rd_i,
  input  reg_addr_t rs1_i,
  input  reg_addr_t rs2_i,
  input  logic      rs1_bypass_i,
  input  logic      rs2_bypass_i,
  output logic      stall_o
);

  // Register 0 is hardwired, so only registers 1..31 carry a busy bit.
  logic [NUM_REGS-1:1] busy_q, busy_d;
  logic [NUM_REGS-1:0] busy_vec;
  logic                issue_stall;
  logic                issue_set;
  logic                rs1_hazard, rs2_hazard;

  assign busy_vec = {busy_q, 1'b0};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    busy_d      = busy_q;
    issue_stall = issue_valid_i && busy_vec[issue_rd_i];
    issue_set   = issue_valid_i && (issue_rd_i != '0) && !issue_stall;
    rs1_hazard  = busy_vec[rs1_i] && !rs1_bypass_i;
    rs2_hazard  = busy_vec[rs2_i] && !rs2_bypass_i;

    // Clear is applied before set so a same-cycle issue keeps the register busy.
    for (int r = 1; r < NUM_REGS; r++) begin
      if (clr_valid_i && (clr_rd_i == reg_addr_t'(r))) busy_d[r] = 1'b0;
      if (issue_set && (issue_rd_i == reg_addr_t'(r))) busy_d[r] = 1'b1;
    end
  end

  assign stall_o = rs1_hazard || rs2_hazard || issue_stall;

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port round-robin writeback arbiter with registered register-file drive.
// Optional same-cycle forwarding outputs are enabled by RF_ARB_BYPASS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req0Valid,
  input  logic [REG_ADDR_W-1:0] Req0RD,
  input  logic [DATA_W-1:0]     Req0Data,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic [REG_ADDR_W-1:0] Req1RD,
  input  logic [DATA_W-1:0]     Req1Data,
  output logic                  Req1Ready,
  input  logic                  IssueValid,
  input  logic [REG_ADDR_W-1:0] IssueRD,
  input  logic [REG_ADDR_W-1:0] RS1,
  input  logic [REG_ADDR_W-1:0] RS2,
  output logic                  Stall,
`ifdef RF_ARB_BYPASS_EN
  output logic                  Byp1Valid,
  output logic [DATA_W-1:0]     Byp1Data,
  output logic                  Byp2Valid,
  output logic [DATA_W-1:0]     Byp2Data,
`endif
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] RD,
  output logic [DATA_W-1:0]     WData
);

  port_e     ptr_q, ptr_d;
  logic      grant0, grant1;
  reg_addr_t grant_rd;
  data_t     grant_data;
  logic      regwrite_q, regwrite_d;
  reg_addr_t rd_q, rd_d;
  data_t     wdata_q, wdata_d;
  logic      rs1_bypass, rs2_bypass;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset) begin
      if (Req0Valid && Req1Valid) begin
        grant0 = (ptr_q == PORT_ALU);
        grant1 = (ptr_q == PORT_LL);
      end else begin
        grant0 = Req0Valid;
        grant1 = Req1Valid;
      end
    end

    grant_rd   = grant1 ? Req1RD   : Req0RD;
    grant_data = grant1 ? Req1Data : Req0Data;

    ptr_d = ptr_q;
    if (grant0 || grant1) ptr_d = other_port(grant1 ? PORT_LL : PORT_ALU);

    // A grant to register 0 completes the handshake but never writes.
    regwrite_d = (grant0 || grant1) && (grant_rd != '0);
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (regwrite_d) begin
      rd_d    = grant_rd;
      wdata_d = grant_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q      <= PORT_ALU;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign Req0Ready = grant0;
  assign Req1Ready = grant1;
  assign RegWrite  = regwrite_q;
  assign RD        = rd_q;
  assign WData     = wdata_q;

`ifdef RF_ARB_BYPASS_EN
  // The value being written this cycle satisfies a source without waiting.
  assign Byp1Valid  = regwrite_q && (rd_q != '0) && (rd_q == RS1);
  assign Byp2Valid  = regwrite_q && (rd_q != '0) && (rd_q == RS2);
  assign Byp1Data   = wdata_q;
  assign Byp2Data   = wdata_q;
  assign rs1_bypass = Byp1Valid;
  assign rs2_bypass = Byp2Valid;
`else
  assign rs1_bypass = 1'b0;
  assign rs2_bypass = 1'b0;
`endif

  rf_scoreboard u_scoreboard (
    .Clk           (Clk),
    .Reset         (Reset),
    .issue_valid_i (IssueValid),
    .issue_rd_i    (IssueRD),
    .clr_valid_i   (grant1),
    .clr_rd_i      (Req1RD),
    .rs1_i         (RS1),
    .rs2_i         (RS2),
    .rs1_bypass_i  (rs1_bypass),
    .rs2_bypass_i  (rs2_bypass),
    .stall_o       (Stall)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of arbitration and busy bits.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Req0Valid, Req1Valid, IssueValid;
  logic [4:0]  Req0RD, Req1RD, IssueRD, RS1, RS2;
  logic [31:0] Req0Data, Req1Data;
  logic        Req0Ready, Req1Ready, Stall, RegWrite;
  logic [4:0]  RD;
  logic [31:0] WData;
`ifdef RF_ARB_BYPASS_EN
  logic        Byp1Valid, Byp2Valid;
  logic [31:0] Byp1Data, Byp2Data;
`endif

  rf_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0RD(Req0RD), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1RD(Req1RD), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .IssueValid(IssueValid), .IssueRD(IssueRD), .RS1(RS1), .RS2(RS2), .Stall(Stall),
`ifdef RF_ARB_BYPASS_EN
    .Byp1Valid(Byp1Valid), .Byp1Data(Byp1Data), .Byp2Valid(Byp2Valid), .Byp2Data(Byp2Data),
`endif
    .RegWrite(RegWrite), .RD(RD), .WData(WData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: who has priority, which registers are outstanding,
  // and what the register-file port should show after the next edge.
  int          m_ptr;
  bit          m_busy [32];
  bit          m_we;
  int          m_rd;
  logic [31:0] m_wd;
  int          g_win;
  logic        obs_r0, obs_r1, obs_stall;

  task automatic model_reset();
    m_ptr = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 1'b0;
    m_rd = 0;
    m_wd = '0;
  endtask

  function automatic bit src_stall(input int rs);
    if (rs == 0 || !m_busy[rs]) return 1'b0;
`ifdef RF_ARB_BYPASS_EN
    if (m_we && m_rd == rs) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic idle();
    Req0Valid = 0; Req0RD = 0; Req0Data = 0;
    Req1Valid = 0; Req1RD = 0; Req1Data = 0;
    IssueValid = 0; IssueRD = 0; RS1 = 0; RS2 = 0;
  endtask

  task automatic apply_reset();
    idle();
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    model_reset();
  endtask

  // One clock of checked operation; inputs must already be driven.
  task automatic cycle();
    int          win, rd;
    bit          istall, exp_stall;
    logic [31:0] d;
    @(negedge Clk);
    win = -1;
    if (Req0Valid && Req1Valid) win = m_ptr;
    else if (Req0Valid)         win = 0;
    else if (Req1Valid)         win = 1;
    istall    = IssueValid && IssueRD != 0 && m_busy[IssueRD];
    exp_stall = src_stall(int'(RS1)) || src_stall(int'(RS2)) || istall;
    obs_r0 = Req0Ready; obs_r1 = Req1Ready; obs_stall = Stall;

    tests_run++;
    if (Req0Ready !== (win == 0)) begin
      tests_failed++; $display("FAIL ready0: got %b expected %b", Req0Ready, win == 0);
    end
    tests_run++;
    if (Req1Ready !== (win == 1)) begin
      tests_failed++; $display("FAIL ready1: got %b expected %b", Req1Ready, win == 1);
    end
    tests_run++;
    if (Stall !== exp_stall) begin
      tests_failed++; $display("FAIL stall: got %b expected %b (rs1=%0d rs2=%0d)", Stall, exp_stall, RS1, RS2);
    end
`ifdef RF_ARB_BYPASS_EN
    tests_run++;
    if (Byp1Valid !== (m_we && m_rd != 0 && m_rd == int'(RS1))) begin
      tests_failed++; $display("FAIL byp1_valid: got %b rd=%0d rs1=%0d", Byp1Valid, m_rd, RS1);
    end
    tests_run++;
    if (Byp2Valid !== (m_we && m_rd != 0 && m_rd == int'(RS2))) begin
      tests_failed++; $display("FAIL byp2_valid: got %b rd=%0d rs2=%0d", Byp2Valid, m_rd, RS2);
    end
`endif

    g_win = win;
    if (win >= 0) begin
      rd = (win == 1) ? int'(Req1RD) : int'(Req0RD);
      d  = (win == 1) ? Req1Data : Req0Data;
      m_ptr = 1 - win;
      if (win == 1 && rd != 0) m_busy[rd] = 1'b0;
      m_we = (rd != 0);
      if (rd != 0) begin m_rd = rd; m_wd = d; end
    end else begin
      m_we = 1'b0;
    end
    if (IssueValid && IssueRD != 0 && !istall) m_busy[IssueRD] = 1'b1;

    @(posedge Clk); #1;
    tests_run++;
    if (RegWrite !== m_we) begin
      tests_failed++; $display("FAIL regwrite: got %b expected %b", RegWrite, m_we);
    end
    if (m_we) begin
      tests_run++;
      if (RD !== m_rd[4:0] || WData !== m_wd) begin
        tests_failed++; $display("FAIL wb_data: got rd=%0d data=%h expected rd=%0d data=%h", RD, WData, m_rd, m_wd);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    Req0Valid = 1; Req1Valid = 1; Req0RD = 3; Req1RD = 4;
    repeat (2) @(posedge Clk);
    #1;
    tests_run++;
    if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready: got %b/%b expected 0/0", Req0Ready, Req1Ready);
    end
    tests_run++;
    if (RegWrite !== 1'b0 || RD !== 5'd0 || WData !== 32'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got we=%b rd=%0d data=%h expected 0/0/0", RegWrite, RD, WData);
    end
    apply_reset();
  endtask

  task automatic test_single_grant();
    Req0Valid = 1; Req0RD = 5; Req0Data = 32'h1234;
    cycle();
    tests_run++;
    if (obs_r0 !== 1'b1 || RegWrite !== 1'b1 || RD !== 5'd5 || WData !== 32'h1234) begin
      tests_failed++; $display("FAIL single: got rdy=%b we=%b rd=%0d data=%h expected 1/1/5/1234", obs_r0, RegWrite, RD, WData);
    end
    idle();
    cycle();
    tests_run++;
    if (RegWrite !== 1'b0 || RD !== 5'd5 || WData !== 32'h1234) begin
      tests_failed++; $display("FAIL hold: got we=%b rd=%0d data=%h expected 0/5/1234", RegWrite, RD, WData);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    Req0Valid = 1; Req0RD = 3; Req1Valid = 1; Req1RD = 4;
    for (int i = 0; i < 4; i++) begin
      Req0Data = $urandom; Req1Data = $urandom;
      cycle();
      tests_run++;
      if (obs_r0 !== (i % 2 == 0) || RegWrite !== 1'b1 || RD !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
        tests_failed++; $display("FAIL alternate[%0d]: got rdy0=%b we=%b rd=%0d", i, obs_r0, RegWrite, RD);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_scoreboard_stall();
    IssueValid = 1; IssueRD = 7;
    cycle();
    IssueValid = 0; RS1 = 7;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (obs_stall !== 1'b1) begin
        tests_failed++; $display("FAIL raw_stall[%0d]: got %b expected 1", i, obs_stall);
      end
    end
    Req1Valid = 1; Req1RD = 7; Req1Data = $urandom;
    cycle();
    tests_run++;
    if (obs_stall !== 1'b1 || obs_r1 !== 1'b1) begin
      tests_failed++; $display("FAIL clear_cycle: got stall=%b rdy1=%b expected 1/1", obs_stall, obs_r1);
    end
    Req1Valid = 0;
    cycle();
    tests_run++;
    if (obs_stall !== 1'b0) begin
      tests_failed++; $display("FAIL raw_release: got %b expected 0", obs_stall);
    end
    idle();
  endtask

  task automatic test_waw();
    IssueValid = 1; IssueRD = 7;
    cycle();
    cycle();
    tests_run++;
    if (obs_stall !== 1'b1) begin
      tests_failed++; $display("FAIL waw_stall: got %b expected 1", obs_stall);
    end
    IssueValid = 0; Req1Valid = 1; Req1RD = 7; Req1Data = $urandom;
    cycle();
    Req1Valid = 0; RS1 = 7;
    cycle();
    tests_run++;
    if (obs_stall !== 1'b0) begin
      tests_failed++; $display("FAIL waw_ignored: got %b expected 0", obs_stall);
    end
    RS1 = 0;
    IssueValid = 1; IssueRD = 9; Req1Valid = 1; Req1RD = 9; Req1Data = $urandom;
    cycle();
    idle();
    cycle();
    RS1 = 9;
    cycle();
    tests_run++;
    if (obs_stall !== 1'b1) begin
      tests_failed++; $display("FAIL set_wins: got %b expected 1", obs_stall);
    end
    RS1 = 0; Req1Valid = 1; Req1RD = 9;
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_rd_zero();
    Req1Valid = 1; Req1RD = 0; Req1Data = 32'hDEAD_BEEF;
    cycle();
    tests_run++;
    if (obs_r1 !== 1'b1 || RegWrite !== 1'b0) begin
      tests_failed++; $display("FAIL rd_zero: got rdy1=%b we=%b expected 1/0", obs_r1, RegWrite);
    end
    Req0Valid = 1; Req0RD = 2; Req1RD = 3;
    cycle();
    tests_run++;
    if (obs_r0 !== 1'b1) begin
      tests_failed++; $display("FAIL rd_zero_ptr: got rdy0=%b expected 1", obs_r0);
    end
    idle();
    cycle();
  endtask

  task automatic test_reset_mid();
    IssueValid = 1; IssueRD = 12;
    cycle();
    IssueValid = 0; Req0Valid = 1; Req0RD = 6; Req0Data = $urandom;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    tests_run++;
    if (Req0Ready !== 1'b0 || RegWrite !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset: got rdy0=%b we=%b expected 0/0", Req0Ready, RegWrite);
    end
    model_reset();
    @(posedge Clk); #1;
    RS1 = 12;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0 || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_state: got we=%b stall=%b expected 0/0", RegWrite, Stall);
    end
    @(negedge Clk);
    Reset = 1'b0;
    idle();
    @(posedge Clk); #1;
    tests_run++;
    if (RegWrite !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_we: got %b expected 0", RegWrite);
    end
  endtask

`ifdef RF_ARB_BYPASS_EN
  task automatic test_bypass();
    IssueValid = 1; IssueRD = 7;
    cycle();
    IssueValid = 0; RS2 = 7; Req1Valid = 1; Req1RD = 7; Req1Data = 32'hCAFE;
    cycle();
    Req1Valid = 0;
    #1;
    tests_run++;
    if (Byp2Valid !== 1'b1 || Byp2Data !== 32'hCAFE || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL bypass: got v=%b d=%h stall=%b expected 1/cafe/0", Byp2Valid, Byp2Data, Stall);
    end
    idle();
    cycle();
  endtask
`endif

  task automatic test_random();
    bit          pend0, pend1;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    pend0 = 0; pend1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(1) == 1) begin
        pend0 = 1; rd0 = 5'($urandom_range(7)); d0 = $urandom;
      end
      if (!pend1 && $urandom_range(1) == 1) begin
        pend1 = 1; rd1 = 5'($urandom_range(7)); d1 = $urandom;
      end
      Req0Valid = pend0; Req0RD = rd0; Req0Data = d0;
      Req1Valid = pend1; Req1RD = rd1; Req1Data = d1;
      IssueValid = ($urandom_range(3) == 0);
      IssueRD = 5'($urandom_range(7));
      RS1 = 5'($urandom_range(7));
      RS2 = 5'($urandom_range(7));
      cycle();
      if (g_win == 0) pend0 = 0;
      if (g_win == 1) pend1 = 0;
    end
    idle();
    cycle();
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    model_reset();
    g_win = -1;
    test_reset();
    test_single_grant();
    test_alternate();
    test_scoreboard_stall();
    test_waw();
    test_rd_zero();
    test_reset_mid();
`ifdef RF_ARB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Clk  input  1  clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Req0Valid  input  1  single-cycle (ALU) writeback request.
REQ-004 Req0RD  input  5  port-0 destination register.
REQ-005 Req0Data  input  32  port-0 write data.
REQ-006 Req0Ready  output  1  port-0 request accepted this cycle.
REQ-007 Req1Valid / Req1RD / Req1Data / Req1Ready  in/in/in/out  1/5/32/1  long-latency (MDU/load) writeback port; same meaning as port 0.
REQ-008 IssueValid  input  1  long-latency op issued this cycle.
REQ-009 IssueRD  input  5  destination of the issued long-latency op.
REQ-010 RS1, RS2  input  5  source registers of the instruction in decode.
REQ-011 Stall  output  1  decode must hold.
REQ-012 RegWrite, RD, WData  output  1/5/32  register-file write port drive.

Function
REQ-013 Handshake: requester holds Valid, RD and Data stable until Ready is seen high; Ready is combinational from the current Valids and the arbitration pointer.
REQ-014 Only one port is granted per cycle; a lone valid requester is always granted in the same cycle.
REQ-015 Both valid: grant goes to the port indicated by the round-robin pointer; on every grant the pointer moves to the other port.
REQ-016 Granted request appears on RegWrite/RD/WData on the following cycle (1-cycle latency, registered outputs); RegWrite is high for exactly one cycle per grant.
REQ-017 Granted request with RD = 0: Ready asserted, pointer advances, RegWrite stays 0.
REQ-018 No grant: RegWrite = 0; RD/WData hold their last values.
REQ-019 Scoreboard: 31 busy bits (registers 1..31); IssueValid with IssueRD != 0 and no IssueStall sets busy[IssueRD] at the clock edge.
REQ-020 Port-1 grant clears busy[Req1RD] at the clock edge; port-0 grants never modify busy bits.
REQ-021 Same-cycle set and clear of the same register: set wins.
REQ-022 Stall = (RS1 != 0 and busy[RS1]) or (RS2 != 0 and busy[RS2]) or IssueStall.
REQ-023 IssueStall (internal) = IssueValid and IssueRD != 0 and busy[IssueRD] (WAW); the issue is ignored while IssueStall is high.
REQ-024 Port-0 request whose RD is busy is still granted; ordering across ports is the pipeline's responsibility.

Reset
REQ-025 Reset clears all busy bits, RegWrite = 0, RD = 0, WData = 0, pointer = port 0; Ready outputs are 0 while Reset is high.
REQ-026 Reset asserted mid-operation discards any pending registered write; no RegWrite pulse occurs in the cycle after Reset deasserts unless a new grant occurred.

Configuration
REQ-027 Macro RF_ARB_BYPASS_EN defined: extra outputs Byp1Valid/Byp1Data and Byp2Valid/Byp2Data (1/32 each); BypNValid = RegWrite and RD != 0 and RD == RSN; BypNData = WData; a source satisfied by bypass does not raise Stall.
REQ-028 RF_ARB_BYPASS_EN undefined: bypass ports absent; Stall exactly as REQ-022.

Structure
REQ-029 Shared package rf_arb_pkg holds REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32 and the port-index constants PORT_ALU = 0, PORT_LL = 1.
REQ-030 Scoreboard (busy bits, set/clear, hazard compare) is the sub-module rf_scoreboard; arbitration and output registers stay in rf_wb_arbiter.

Verification
REQ-031 Req0Valid=1, Req0RD=5, Req0Data=0x1234 alone -> Req0Ready=1 same cycle; next cycle RegWrite=1, RD=5, WData=0x1234.
REQ-032 Both valid for 4 cycles after reset (RD 3 and 4) -> grants alternate 0,1,0,1; RegWrite high on 4 consecutive cycles.
REQ-033 IssueValid, IssueRD=7; then RS1=7 -> Stall=1 until a port-1 grant with Req1RD=7; Stall=0 the cycle after that grant.
REQ-034 Issue RD=7 twice without a clear -> second issue raises Stall and is ignored; one port-1 write to 7 clears busy; same-cycle issue and clear of 9 leaves busy[9]=1.
REQ-035 Req1RD=0 grant -> Req1Ready=1, no RegWrite; Reset asserted in the cycle after a grant -> RegWrite=0, all busy clear.
REQ-036 (RF_ARB_BYPASS_EN) Port-1 writes 0xCAFE to register 7 while RS2=7 -> next cycle Byp2Valid=1, Byp2Data=0xCAFE, Stall=0.
